audio_mini_led_driver: RTL
==========================

// Module: audio_mini_led_driver
// PURPOSE
//   Downstream of the audio-mini LED PIO: consumes its 4-bit LED request pattern and drives the
//   physical LEDs with PWM brightness and linear fade-in/fade-out. A static on/off request from
//   software becomes a smooth, brightness-limited LED transition. Single clock domain; LEDs are
//   active-high.
// PARAMETERS
//   NUM_LEDS       4    number of LED channels (width of led_req/led_out)
//   PWM_DIV        64   clk cycles per PWM count step (>=1)
//   RAMP_STEP      8    level change per PWM period while fading (1..255)
//   BLINK_PERIODS  128  PWM periods per blink half-phase (only with AUDIO_MINI_LED_BLINK_EN)
// PORTS
//   clk         in   1         clock
//   reset_n     in   1         asynchronous, active-low reset
//   led_req     in   NUM_LEDS  on/off request per LED (from the PIO out_port)
//   brightness  in   8         global on-level, 0..255, quasi-static
//   blink_mask  in   NUM_LEDS  per-LED blink enable (port exists only with AUDIO_MINI_LED_BLINK_EN)
//   led_out     out  NUM_LEDS  PWM drive to LED pins, registered
//   busy        out  NUM_LEDS  1 = channel is fading (state != IDLE)
// BEHAVIOUR
//   - Reset: prescaler=0, pwm_cnt=0, every level=0, every state=IDLE, led_out=0, busy=0, blink phase=0.
//   - Prescaler: counts 0..PWM_DIV-1; pwm_tick=1 when it equals PWM_DIV-1, then wraps to 0.
//     PWM_DIV=1 gives pwm_tick every cycle.
//   - pwm_cnt: 8-bit; increments on pwm_tick; wraps 255->0.
//     ramp_tick = pwm_tick while pwm_cnt==255 (once per 256*PWM_DIV clks).
//   - Per channel: target = led_req[i] ? brightness : 0. State FSM, evaluated every clk:
//       IDLE: level==target. Go to UP if target>level, DOWN if target<level.
//       UP:   on ramp_tick, level <= min(level+RAMP_STEP, target). 9-bit add, no wrap.
//       DOWN: on ramp_tick, level <= max(level-RAMP_STEP, target). 9-bit signed compare, no underflow.
//       UP/DOWN go to IDLE the cycle after level==target.
//       Target reversal mid-fade (req toggle or brightness change) redirects UP<->DOWN from the
//       current level; level never jumps.
//   - Output: led_out[i] <= (level[i] > pwm_cnt). Registered, 1 clk latency.
//     level=0 -> always 0; level=255 -> high 255 of 256 counts.
//   - busy[i] = (state[i] != IDLE). Combinational from the state register.
//   - led_req is assumed synchronous to clk (PIO in the same domain); no synchronizer.
//   - Reset asserted mid-fade: all channels return to level 0 immediately; no residual fade.
// CONFIGURATION
//   AUDIO_MINI_LED_BLINK_EN defined:
//     - blink_mask port exists.
//     - Blink counter counts ramp_ticks; blink_phase toggles every BLINK_PERIODS ramp_ticks.
//     - When blink_phase=1 and blink_mask[i]=1, led_out[i] is forced 0. level/FSM keep running.
//   AUDIO_MINI_LED_BLINK_EN undefined: no blink_mask port, no blink counter, no gating logic.
// STRUCTURE
//   - Package audio_mini_led_pkg: typedef enum {IDLE, UP, DOWN} led_fade_state_t;
//     localparam LED_LEVEL_W=8, PWM_CNT_MAX=8'hFF.
//   - Top holds the prescaler, pwm_cnt, ramp_tick and the optional blink counter; these are shared.
//   - Sub-module led_fade_channel is generated NUM_LEDS times.
//     Inputs: clk, reset_n, req, brightness, ramp_tick, pwm_cnt.
//     Outputs: level, pwm_bit, busy.
// TESTING  (PWM_DIV=1, RAMP_STEP=64 unless noted)
//   1 Reset: hold reset_n=0 with led_req=4'hF -> led_out=0, busy=0.
//     After release with brightness=0 -> busy stays 0 and led_out stays 0.
//   2 Fade up: brightness=255, led_req=4'b0001 ->
//     - busy[0]=1 within 1 clk;
//     - level 64,128,192,255 on successive ramp_ticks;
//     - busy[0]=0 one clk after reaching 255;
//     - duty then 255/256.
//   3 Duty: brightness=128 steady ->
//     - led_out[0] high exactly 128 clks of every 256-clk PWM period;
//     - other channels stay 0.
//   4 Reversal: led_req[0] 1->0 at level 128 (brightness=255) ->
//     - state DOWN, no jump;
//     - level 64 then 0 on the next ramp_ticks; IDLE after.
//   5 Saturation: RAMP_STEP=100, brightness=150 -> levels 100,150 (no overshoot).
//     Fading down from 150 -> 50,0 (no underflow).
//   6 Blink (macro on, BLINK_PERIODS=2): led_req=4'hF, brightness=255, blink_mask=4'b1010 ->
//     - LEDs 1,3 dark for 2 periods, lit for 2, alternating;
//     - LEDs 0,2 never gated.
//     Reset asserted mid-test -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/audio_mini_led_pkg.sv
// Shared types and constants for the audio-mini LED driver.
package audio_mini_led_pkg;

    localparam int         LED_LEVEL_W = 8;
    localparam logic [7:0] PWM_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } led_fade_state_t;

endpackage

// File: rtl/audio_mini_led_driver_fade_channel.sv
// One LED channel: linear fade FSM toward the requested level plus PWM comparator.
module led_fade_channel
    import audio_mini_led_pkg::*;
#(
    parameter int RAMP_STEP = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req,
    input  logic [LED_LEVEL_W-1:0] brightness,
    input  logic                   ramp_tick,
    input  logic [7:0]             pwm_cnt,
    output logic [LED_LEVEL_W-1:0] level,
    output logic                   pwm_bit,
    output logic                   busy
);

    led_fade_state_t        state_reg;
    logic [LED_LEVEL_W-1:0] level_reg;
    logic [LED_LEVEL_W-1:0] target;
    logic [LED_LEVEL_W:0]   sum_up;
    logic signed [LED_LEVEL_W:0] diff_dn;
    logic [LED_LEVEL_W-1:0] level_up_next;
    logic [LED_LEVEL_W-1:0] level_dn_next;

    assign target = req ? brightness : '0;

    // Extra bit on both paths so a step can never wrap past 255 or below 0.
    assign sum_up  = {1'b0, level_reg} + 9'(RAMP_STEP);
    assign diff_dn = $signed({1'b0, level_reg}) - $signed(9'(RAMP_STEP));

    assign level_up_next = (sum_up > {1'b0, target}) ? target : sum_up[LED_LEVEL_W-1:0];
    assign level_dn_next = (diff_dn > $signed({1'b0, target})) ? diff_dn[LED_LEVEL_W-1:0] : target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            level_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (target > level_reg)      state_reg <= UP;
                    else if (target < level_reg) state_reg <= DOWN;
                end
                UP: begin
                    // A target that dropped below the level turns the fade around in place.
                    if (level_reg == target)     state_reg <= IDLE;
                    else if (target < level_reg) state_reg <= DOWN;
                    else if (ramp_tick)          level_reg <= level_up_next;
                end
                DOWN: begin
                    if (level_reg == target)     state_reg <= IDLE;
                    else if (target > level_reg) state_reg <= UP;
                    else if (ramp_tick)          level_reg <= level_dn_next;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign level   = level_reg;
    assign pwm_bit = (level_reg > pwm_cnt);
    assign busy    = (state_reg != IDLE);

endmodule

// File: rtl/audio_mini_led_driver.sv
// PWM/fade LED driver behind the audio-mini LED PIO.
// Optional blink gating is built when AUDIO_MINI_LED_BLINK_EN is defined.
module audio_mini_led_driver
    import audio_mini_led_pkg::*;
#(
    parameter int NUM_LEDS      = 4,
    parameter int PWM_DIV       = 64,
    parameter int RAMP_STEP     = 8
`ifdef AUDIO_MINI_LED_BLINK_EN
    ,
    parameter int BLINK_PERIODS = 128
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_LEDS-1:0]    led_req,
    input  logic [LED_LEVEL_W-1:0] brightness,
`ifdef AUDIO_MINI_LED_BLINK_EN
    input  logic [NUM_LEDS-1:0]    blink_mask,
`endif
    output logic [NUM_LEDS-1:0]    led_out,
    output logic [NUM_LEDS-1:0]    busy
);

    localparam int                PRESC_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PWM_DIV - 1);

    logic [PRESC_W-1:0]     presc_reg;
    logic [7:0]             pwm_cnt_reg;
    logic                   pwm_tick;
    logic                   ramp_tick;
    logic [NUM_LEDS-1:0]    pwm_bit;
    logic [NUM_LEDS-1:0]    led_out_reg;
    logic [LED_LEVEL_W-1:0] ch_level_unused [NUM_LEDS];

    assign pwm_tick  = (presc_reg == PRESC_MAX);
    assign ramp_tick = pwm_tick && (pwm_cnt_reg == PWM_CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg   <= '0;
            pwm_cnt_reg <= '0;
        end else begin
            presc_reg <= pwm_tick ? '0 : presc_reg + 1'b1;
            if (pwm_tick) pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : gen_ch
            led_fade_channel #(
                .RAMP_STEP (RAMP_STEP)
            ) u_ch (
                .clk        (clk),
                .reset_n    (reset_n),
                .req        (led_req[gi]),
                .brightness (brightness),
                .ramp_tick  (ramp_tick),
                .pwm_cnt    (pwm_cnt_reg),
                .level      (ch_level_unused[gi]),
                .pwm_bit    (pwm_bit[gi]),
                .busy       (busy[gi])
            );
        end
    endgenerate

`ifdef AUDIO_MINI_LED_BLINK_EN
    localparam int                BLINK_W   = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIODS - 1);

    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;

    // Blink phase advances in whole PWM periods so gating never splits a period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (ramp_tick) begin
            if (blink_cnt_reg == BLINK_MAX) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) led_out_reg <= '0;
        else          led_out_reg <= pwm_bit & ~({NUM_LEDS{blink_phase_reg}} & blink_mask);
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) led_out_reg <= '0;
        else          led_out_reg <= pwm_bit;
    end
`endif

    assign led_out = led_out_reg;

endmodule
